// File: rtl/seg_reader_pkg.sv
// Shared definitions for the seven-segment digit reader: segment codes for
// the eight digits and blank, the reader FSM state type, and the code lookup.
package seg_reader_pkg;

    // Active-low segment codes packed as {A,B,C,D,E,F,G}
    localparam logic [6:0] SEG_DIGIT_0 = 7'h01;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h4F;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h12;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h06;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h4C;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h24;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h20;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h0F;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    // Width of the stability counter; covers STABLE_CYCLES up to 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] digit;
    } seg_lut_t;

    // Map a segment code to {valid, digit}; blank and unknown codes are not valid
    function automatic seg_lut_t seg_decode(input logic [6:0] code);
        seg_lut_t r;
        r.valid = 1'b1;
        r.digit = 3'd0;
        case (code)
            SEG_DIGIT_0: r.digit = 3'd0;
            SEG_DIGIT_1: r.digit = 3'd1;
            SEG_DIGIT_2: r.digit = 3'd2;
            SEG_DIGIT_3: r.digit = 3'd3;
            SEG_DIGIT_4: r.digit = 3'd4;
            SEG_DIGIT_5: r.digit = 3'd5;
            SEG_DIGIT_6: r.digit = 3'd6;
            SEG_DIGIT_7: r.digit = 3'd7;
            default:     r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_reader_stable.sv
// seg_stable: stability filter for the sampled segment pattern. Counts how
// many consecutive identical samples have been seen and strobes accept_o on
// the single edge where that count first reaches STABLE_CYCLES.
module seg_stable
    import seg_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] seg_i,
    output logic       change_o,
    output logic       accept_o,
    output logic [6:0] pattern_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       prev_q;
    logic [6:0]       prev_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             same_w;

    assign same_w = (seg_i == prev_q);

    // Restart the count on any new pattern, otherwise count up to saturation
    always_comb begin
        prev_d = seg_i;
        cnt_d  = cnt_q;
        if (!same_w) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Sample register and counter; reset forgets any pattern in progress
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= SEG_BLANK;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    // Saturation at STABLE_CYCLES keeps accept from repeating on a held pattern
    assign change_o  = !same_w;
    assign accept_o  = same_w && (cnt_q == CNT_ACC);
    assign pattern_o = prev_q;

endmodule

// File: rtl/seg_reader.sv
// seg_reader: decodes an active-low seven-segment display into a digit,
// tracks whether a digit is held, and classifies each newly accepted digit
// as a step up, step down or sequence error modulo max_count+1.
// Optional build macro SEG_READER_SYNC_EN inserts a two-flop input
// synchronizer (reset to blank) ahead of the stability filter.
module seg_reader
    import seg_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic [2:0] max_count,
    output logic [2:0] value,
    output logic       locked,
    output logic       step_up,
    output logic       step_down,
    output logic       seq_err,
    output logic       pat_err
);

    logic [6:0] seg_raw;
    logic [6:0] seg_filt;
    logic       change_w;
    logic       accept_w;
    logic [6:0] pattern_w;

    assign seg_raw = {A, B, C, D, E, F, G};

`ifdef SEG_READER_SYNC_EN
    logic [6:0] seg_sync1_q;
    logic [6:0] seg_sync2_q;

    // Two-flop synchronizer for the asynchronous segment lines
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_sync1_q <= SEG_BLANK;
            seg_sync2_q <= SEG_BLANK;
        end else begin
            seg_sync1_q <= seg_raw;
            seg_sync2_q <= seg_sync1_q;
        end
    end

    assign seg_filt = seg_sync2_q;
`else
    assign seg_filt = seg_raw;
`endif

    seg_stable #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stable (
        .clk_i     (clock),
        .rst_ni    (reset),
        .seg_i     (seg_filt),
        .change_o  (change_w),
        .accept_o  (accept_w),
        .pattern_o (pattern_w)
    );

    state_e     state_q;
    state_e     state_d;
    logic       from_lock_q;
    logic       from_lock_d;
    logic [2:0] value_q;
    logic [2:0] value_d;
    logic       step_up_q;
    logic       step_up_d;
    logic       step_down_q;
    logic       step_down_d;
    logic       seq_err_q;
    logic       seq_err_d;
    logic       pat_err_q;
    logic       pat_err_d;

    seg_lut_t   lut_w;
    logic       locked_w;
    logic [3:0] mod_w;
    logic [3:0] prev_w;
    logic [3:0] dig_w;
    logic [3:0] up_exp_w;
    logic [3:0] dn_exp_w;

    assign lut_w = seg_decode(pattern_w);

    // A glitch out of LOCKED keeps the lock until something new is accepted
    assign locked_w = (state_q == ST_LOCKED) ||
                      ((state_q == ST_SETTLE) && from_lock_q);

    // Neighbour digits of the held value modulo max_count+1 (1..8)
    always_comb begin
        mod_w    = {1'b0, max_count} + 4'd1;
        prev_w   = {1'b0, value_q};
        dig_w    = {1'b0, lut_w.digit};
        up_exp_w = (prev_w + 4'd1) % mod_w;
        dn_exp_w = (prev_w + mod_w - 4'd1) % mod_w;
    end

    // Reader FSM, digit capture and classification of accepted patterns
    always_comb begin
        state_d     = state_q;
        from_lock_d = from_lock_q;
        value_d     = value_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        seq_err_d   = 1'b0;
        pat_err_d   = 1'b0;
        if (change_w) begin
            // Remember whether this settle began from a held digit
            if (state_q != ST_SETTLE) begin
                from_lock_d = (state_q == ST_LOCKED);
            end
            state_d = ST_SETTLE;
        end else if (accept_w) begin
            from_lock_d = 1'b0;
            if (lut_w.valid) begin
                state_d = ST_LOCKED;
                value_d = lut_w.digit;
                // Settling back onto the held digit is a re-confirmation, not a step
                if (locked_w && (lut_w.digit != value_q)) begin
                    if (lut_w.digit > max_count) begin
                        seq_err_d = 1'b1;
                    end else if (dig_w == up_exp_w) begin
                        step_up_d = 1'b1;
                    end else if (dig_w == dn_exp_w) begin
                        step_down_d = 1'b1;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
            end else begin
                state_d = ST_EMPTY;
                if (pattern_w != SEG_BLANK) begin
                    pat_err_d = 1'b1;
                end
            end
        end
    end

    // State, held digit and single-cycle event pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            from_lock_q <= 1'b0;
            value_q     <= 3'd0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            seq_err_q   <= 1'b0;
            pat_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            from_lock_q <= from_lock_d;
            value_q     <= value_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            seq_err_q   <= seq_err_d;
            pat_err_q   <= pat_err_d;
        end
    end

    assign value     = value_q;
    assign locked    = locked_w;
    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign seq_err   = seq_err_q;
    assign pat_err   = pat_err_q;

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader (STABLE_CYCLES = 3); one line per transaction.
module tb_seg_reader;

`ifdef SEG_READER_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clock;
    logic       reset;
    logic [6:0] seg;
    logic [2:0] max_count;
    logic [2:0] value;
    logic       locked;
    logic       step_up;
    logic       step_down;
    logic       seq_err;
    logic       pat_err;

    int         n_cmp;
    int         n_err;
    logic [2:0] v_prev;
    logic       l_prev;

    seg_reader #(.STABLE_CYCLES(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .A         (seg[6]),
        .B         (seg[5]),
        .C         (seg[4]),
        .D         (seg[3]),
        .E         (seg[2]),
        .F         (seg[1]),
        .G         (seg[0]),
        .max_count (max_count),
        .value     (value),
        .locked    (locked),
        .step_up   (step_up),
        .step_down (step_down),
        .seq_err   (seq_err),
        .pat_err   (pat_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Check pulses {up,down,seq,pat}, value and locked together
    task automatic chk_outs(input string tag, input logic [3:0] p, input logic [2:0] v, input logic l);
        chk({tag, ".pulse"}, {4'd0, step_up, step_down, seq_err, pat_err}, {4'd0, p});
        chk({tag, ".value"}, {5'd0, value}, {5'd0, v});
        chk({tag, ".locked"}, {7'd0, locked}, {7'd0, l});
    endtask

    // Drive a pattern, expect acceptance exactly LAT edges later, then quiet
    task automatic apply(input string tag, input logic [6:0] s, input logic [2:0] mc,
                         input logic [3:0] p, input logic [2:0] v, input logic l);
        seg       = s;
        max_count = mc;
        for (int i = 1; i < LAT; i++) begin
            tick();
            chk_outs({tag, ".wait"}, 4'b0000, v_prev, l_prev);
        end
        tick();
        chk_outs({tag, ".acc"}, p, v, l);
        tick();
        chk_outs({tag, ".after"}, 4'b0000, v, l);
        $display("txn %-10s seg=%02h max=%0d -> up=%0b dn=%0b seq=%0b pat=%0b value=%0d locked=%0b",
                 tag, s, mc, step_up, step_down, seq_err, pat_err, value, locked);
        v_prev = v;
        l_prev = l;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        seg       = 7'h7F;
        max_count = 3'd7;
        v_prev    = 3'd0;
        l_prev    = 1'b0;

        #2;
        chk_outs("rst_async", 4'b0000, 3'd0, 1'b0);
        tick();
        tick();
        chk_outs("rst_hold", 4'b0000, 3'd0, 1'b0);
        $display("txn reset      value=%0d locked=%0b", value, locked);

        reset = 1'b1;
        apply("first_0", 7'h01, 3'd7, 4'b0000, 3'd0, 1'b1);
        apply("dn_0_7",  7'h0F, 3'd7, 4'b0100, 3'd7, 1'b1);
        apply("up_7_0",  7'h01, 3'd7, 4'b1000, 3'd0, 1'b1);
        apply("dn_0_7b", 7'h0F, 3'd7, 4'b0100, 3'd7, 1'b1);
        apply("seq_7_2", 7'h12, 3'd7, 4'b0010, 3'd2, 1'b1);

        // One-cycle glitch to 06 and back to 12: lock and value must hold
        seg = 7'h06;
        tick();
        chk_outs("glitch.on", 4'b0000, 3'd2, 1'b1);
        seg = 7'h12;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            chk_outs("glitch.back", 4'b0000, 3'd2, 1'b1);
        end
        $display("txn glitch     seg=06->12 value=%0d locked=%0b", value, locked);

        apply("dn_2_1",  7'h4F, 3'd7, 4'b0100, 3'd1, 1'b1);
        apply("seq_1_4", 7'h4C, 3'd7, 4'b0010, 3'd4, 1'b1);
        apply("pat_33",  7'h33, 3'd7, 4'b0001, 3'd4, 1'b0);
        apply("blank",   7'h7F, 3'd7, 4'b0000, 3'd4, 1'b0);
        apply("first_4", 7'h4C, 3'd4, 4'b0000, 3'd4, 1'b1);
        apply("up_mod5", 7'h01, 3'd4, 4'b1000, 3'd0, 1'b1);
        apply("seq_big", 7'h20, 3'd4, 4'b0010, 3'd6, 1'b1);
        apply("seq_m2",  7'h01, 3'd1, 4'b0010, 3'd0, 1'b1);
        apply("up_m2",   7'h4F, 3'd1, 4'b1000, 3'd1, 1'b1);

        // Reset in the middle of settling on 06 discards the pending pattern
        seg       = 7'h06;
        max_count = 3'd7;
        tick();
        chk_outs("settle", 4'b0000, 3'd1, 1'b1);
        reset = 1'b0;
        #1;
        chk_outs("rst_mid", 4'b0000, 3'd0, 1'b0);
        tick();
        chk_outs("rst_mid.hold", 4'b0000, 3'd0, 1'b0);
        $display("txn reset_mid  value=%0d locked=%0b", value, locked);
        reset  = 1'b1;
        v_prev = 3'd0;
        l_prev = 1'b0;
        apply("rst_06", 7'h06, 3'd7, 4'b0000, 3'd3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
